// File: rtl/fp_pkg.sv
// Shared IEEE-754 format helpers for the pipelined FP multiplier.
package fp_pkg;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}.
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int fmt_e(input int n);
        return (n == 64) ? 11 : 8;
    endfunction

    function automatic int fmt_m(input int n);
        return (n == 64) ? 52 : 23;
    endfunction

    function automatic int fmt_bias(input int n);
        return (n == 64) ? 1023 : 127;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
    function automatic logic [63:0] qnan_bits(input int n);
        return (n == 64) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final multiplier stage: normalise the significand product, round to nearest
// even, resolve overflow / flush-to-zero, and pack the result word.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                         sign,
    input  logic signed [fmt_e(N)+1:0]   es,
    input  logic [2*fmt_m(N)+1:0]        prod,
    input  logic                         special,
    input  logic [N-1:0]                 spec_res,
    input  logic [3:0]                   spec_flags,
    output logic [N-1:0]                 res,
    output logic [3:0]                   flags
);
    localparam int E = fmt_e(N);
    localparam int M = fmt_m(N);
    localparam logic signed [E+1:0] ES_MAX = (E+2)'((2**E) - 1);

    logic                shift;
    logic [M-1:0]        frac;
    logic                guard;
    logic                sticky;
    logic                round_up;
    logic                carry;
    logic [M-1:0]        frac_rnd;
    logic signed [E+1:0] es_norm;
    logic signed [E+1:0] es_fin;

    // Normalise, round, then choose between special, overflow, FTZ and normal packing.
    always_comb begin
        shift    = prod[2*M+1];
        frac     = shift ? prod[2*M:M+1] : prod[2*M-1:M];
        guard    = shift ? prod[M] : prod[M-1];
        sticky   = shift ? (|prod[M-1:0]) : (|prod[M-2:0]);
        round_up = guard & (frac[0] | sticky);
        {carry, frac_rnd} = {1'b0, frac} + {{M{1'b0}}, round_up};
        // A rounding carry turns 1.111..1 into 10.000..0; the fraction is already zero.
        es_norm  = es + {{(E+1){1'b0}}, shift};
        es_fin   = es_norm + {{(E+1){1'b0}}, carry};

        res   = {sign, es_fin[E-1:0], frac_rnd};
        flags = '0;
        flags[FLAG_INEXACT] = guard | sticky;

        if (special) begin
            res   = spec_res;
            flags = spec_flags;
        end else if (es_fin >= ES_MAX) begin
            res = {sign, {E{1'b1}}, {M{1'b0}}};
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
        end else if (es_fin[E+1] || (es_fin == '0)) begin
            res = {sign, {(N-1){1'b0}}};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage IEEE-754 multiplier (binary32 or binary64) with valid/ready
// handshake and a pass-through tag. Subnormal inputs read as zero, tiny
// results flush to zero, NaN outputs are always the canonical quiet NaN.
module fmul_pipe
    import fp_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags
);
    localparam int E    = fmt_e(N);
    localparam int M    = fmt_m(N);
    localparam int BIAS = fmt_bias(N);
    localparam logic signed [E+1:0] BIAS_S = (E+2)'(BIAS);
    localparam logic [N-1:0]        QNAN   = N'(qnan_bits(N));

    if (N != 32 && N != 64) begin : g_bad_width
        $error("fmul_pipe: N must be 32 or 64");
    end

    function automatic fp_class_e classify(input logic [N-1:0] x);
        if (x[N-2:M] == '0) return FP_ZERO;
        if (x[N-2:M] == '1) return (x[M-1:0] == '0) ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

    logic adv;

    fp_class_e           cls_a;
    fp_class_e           cls_b;
    logic                s1_sign_c;
    logic signed [E+1:0] s1_es_c;
    logic                s1_special_c;
    logic [N-1:0]        s1_spec_res_c;
    logic [3:0]          s1_spec_flags_c;

    logic                s1_valid;
    logic [TAG_W-1:0]    s1_tag;
    logic                s1_sign;
    logic signed [E+1:0] s1_es;
    logic [M:0]          s1_sig_a;
    logic [M:0]          s1_sig_b;
    logic                s1_special;
    logic [N-1:0]        s1_spec_res;
    logic [3:0]          s1_spec_flags;

    logic [2*M+1:0]      prod_c;

    logic                s2_valid;
    logic [TAG_W-1:0]    s2_tag;
    logic                s2_sign;
    logic signed [E+1:0] s2_es;
    logic [2*M+1:0]      s2_prod;
    logic                s2_special;
    logic [N-1:0]        s2_spec_res;
    logic [3:0]          s2_spec_flags;

    logic [N-1:0]        rp_res;
    logic [3:0]          rp_flags;

    // The whole pipe moves together: it advances unless a result is stuck at the output.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Classify operands, form the biased exponent sum and preselect special results.
    always_comb begin
        cls_a           = classify(in_a);
        cls_b           = classify(in_b);
        s1_sign_c       = in_a[N-1] ^ in_b[N-1];
        s1_es_c         = {2'b00, in_a[N-2:M]} + {2'b00, in_b[N-2:M]} - BIAS_S;
        s1_special_c    = 1'b1;
        s1_spec_res_c   = '0;
        s1_spec_flags_c = '0;
        if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            s1_spec_res_c = QNAN;
        end else if ((cls_a == FP_INF && cls_b == FP_ZERO) ||
                     (cls_a == FP_ZERO && cls_b == FP_INF)) begin
            s1_spec_res_c = QNAN;
            s1_spec_flags_c[FLAG_INVALID] = 1'b1;
        end else if (cls_a == FP_INF || cls_b == FP_INF) begin
            s1_spec_res_c = {s1_sign_c, {E{1'b1}}, {M{1'b0}}};
        end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
            s1_spec_res_c = {s1_sign_c, {(N-1){1'b0}}};
        end else begin
            s1_special_c = 1'b0;
        end
    end

    // Stage 1 register: unpacked operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_tag        <= in_tag;
                s1_sign       <= s1_sign_c;
                s1_es         <= s1_es_c;
                s1_sig_a      <= {1'b1, in_a[M-1:0]};
                s1_sig_b      <= {1'b1, in_b[M-1:0]};
                s1_special    <= s1_special_c;
                s1_spec_res   <= s1_spec_res_c;
                s1_spec_flags <= s1_spec_flags_c;
            end
        end
    end

    assign prod_c = {{(M+1){1'b0}}, s1_sig_a} * {{(M+1){1'b0}}, s1_sig_b};

    // Stage 2 register: full-width significand product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_tag        <= s1_tag;
                s2_sign       <= s1_sign;
                s2_es         <= s1_es;
                s2_prod       <= prod_c;
                s2_special    <= s1_special;
                s2_spec_res   <= s1_spec_res;
                s2_spec_flags <= s1_spec_flags;
            end
        end
    end

    fp_round_pack #(.N(N)) u_round_pack (
        .sign       (s2_sign),
        .es         (s2_es),
        .prod       (s2_prod),
        .special    (s2_special),
        .spec_res   (s2_spec_res),
        .spec_flags (s2_spec_flags),
        .res        (rp_res),
        .flags      (rp_flags)
    );

    // Output register: holds the presented result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_res   <= rp_res;
                out_tag   <= s2_tag;
                out_flags <= rp_flags;
            end
        end
    end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Pipelined IEEE-754 binary multiplier, parametrised for single (N=32) or double (N=64) precision.
- Three stages with valid/ready handshake and a pass-through tag.
- Round-to-nearest-even, canonical NaN, DAZ/FTZ subnormal policy, four exception flags.
- Sits between the issue logic and the writeback FIFO of the FP datapath; replaces the combinational multiplier on timing-critical paths.

Parameters:
- N, 32, operand/result width; legal values 32 and 64 only; any other value is an elaboration error.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts result.
- out_res  out  N  product.
- out_tag  out  TAG_W  tag of this result.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Field widths: E=8/M=23/BIAS=127 for N=32; E=11/M=52/BIAS=1023 for N=64.
- Reset (rst_n low at a clock edge): all stage valid bits clear; out_valid=0, out_res=0, out_tag=0, out_flags=0. Operations in flight are discarded. in_ready=1 in the cycle after reset deasserts.
- Handshake:
  - Global advance enable adv = ~out_valid | out_ready; in_ready = adv.
  - A transfer occurs on in_valid&in_ready; a result is consumed on out_valid&out_ready.
  - When adv=0, every stage holds, including bubbles.
  - out_res, out_tag and out_flags are stable while out_valid&~out_ready.
- Latency: exactly 3 cycles from accept to out_valid with no stall; throughput 1 per cycle; results in order.
- S1, unpack/classify:
  - Sign = sa^sb.
  - Exponent field 0 means zero: DAZ, mantissa ignored.
  - Exponent field all-ones with mantissa 0 means infinity; with mantissa nonzero it means NaN.
  - Biased exponent sum es = ea+eb-BIAS, computed signed at E+2 bits.
  - Special result selected here and carried down the pipe:
    - Any NaN, or inf*zero: canonical qNaN (sign 0, exp all-ones, mantissa MSB 1, rest 0). inf*zero also sets invalid. NaN inputs do not set invalid (no sNaN distinction).
    - Inf*nonzero: signed infinity, no flags.
    - Zero*finite: signed zero, no flags.
- S2: unsigned (M+1)x(M+1) product of significands with hidden bit 1; 2M+2-bit result.
- S3, normalise/round/pack:
  - If product MSB is set: shift right 1, es+1.
  - Keep M fraction bits L, guard G, sticky S (OR of the remaining bits).
  - Round up when G&(L|S); a round carry-out renormalises and increments es.
  - inexact = G|S.
  - es >= 2^E-1: signed infinity; set overflow and inexact.
  - es <= 0: signed zero (FTZ); set underflow and inexact.
  - Otherwise pack sign, es[E-1:0] and fraction.
  - Special results from S1 bypass rounding with their preset flags.
- A simultaneous accept and consume in a full pipe is legal and sustains full throughput.

Decomposition:
- Package fp_pkg holds:
  - fmt constants (E, M, BIAS) as functions of N;
  - canonical-qNaN constant function;
  - class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN};
  - flag index constants.
- One sub-module, fp_round_pack: combinational S3 logic (normalise, RNE, overflow/FTZ, pack). It can be unit-tested standalone.

Test Plan (N=32 unless noted):
- 0x3FC00000*0x40000000, tag 5 -> 3 cycles later 0x40400000, tag 5, flags 0000.
- 0x7F800000*0x00000000 -> 0x7FC00000, flags 1000. 0xFF800000*0x40000000 -> 0xFF800000, flags 0000.
- Rounding and FTZ:
  - 0x3F800001*0x3F800001 -> 0x3F800002, flags 0001.
  - 0x7F000000*0x7F000000 -> 0x7F800000, flags 0101.
  - 0x00800000*0x00800000 -> 0x00000000, flags 0011.
- Backpressure: issue tags 1,2,3 back-to-back with out_ready=0 -> out_valid high from cycle 3, in_ready low, outputs held. Raise out_ready -> tags 1,2,3 in order on consecutive cycles.
- Reset mid-flight: three ops in pipe, pull rst_n low one cycle -> next cycle out_valid=0 and all outputs 0; no stale result ever emerges.
- N=64: 0x3FF8000000000000*0x4000000000000000 -> 0x4008000000000000, flags 0000. 0x7FF0000000000001*0x3FF0000000000000 -> 0x7FF8000000000000, flags 0000.
